// File: rtl/cifar10_argmax_classifier.sv
// Final CIFAR-10 stage: launches the dense output layer, scans its logits and
// holds argmax index, winning score and top-1/top-2 margin with a sticky done.
module cifar10_argmax_classifier #(
  parameter int unsigned N_CLASSES    = 10,
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        up_start,
  input  logic        up_done,
  output logic [3:0]  up_read_addr,
  input  logic [31:0] up_read_data,
  output logic        busy,
  output logic        done,
  output logic [3:0]  class_idx,
  output logic [31:0] max_score,
  output logic [31:0] margin
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);
  localparam logic [DATA_W-1:0] MIN_SCORE = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_UP,
    S_SCAN,
    S_FINISH,
    S_DONE
  } state_t;

  state_t                   state;
  logic [IDX_W-1:0]         cons_idx;
  logic [IDX_W-1:0]         best_idx;
  logic signed [DATA_W-1:0] best;
  logic signed [DATA_W-1:0] second;
  logic signed [DATA_W-1:0] logit;
  logic                     fill;
  logic [DATA_W:0]          diff_c;

  assign logit  = up_read_data;
  // best >= second always, so the 33-bit difference is non-negative and fits 32 bits
  assign diff_c = {best[DATA_W-1], best} - {second[DATA_W-1], second};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      up_start     <= 1'b0;
      up_read_addr <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      class_idx    <= '0;
      max_score    <= '0;
      margin       <= '0;
      cons_idx     <= '0;
      best_idx     <= '0;
      best         <= '0;
      second       <= '0;
      fill         <= 1'b0;
    end else begin
      up_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            up_start <= 1'b1;
            busy     <= 1'b1;
            state    <= S_WAIT_UP;
          end
        end
        S_WAIT_UP: begin
          if (up_done) begin
            up_read_addr <= '0;
            cons_idx     <= '0;
            fill         <= (READ_LATENCY != 0);
            state        <= S_SCAN;
          end
        end
        S_SCAN: begin
          // address leads consumed data by READ_LATENCY and parks on the last logit
          fill <= 1'b0;
          if (up_read_addr != LAST_IDX) begin
            up_read_addr <= up_read_addr + IDX_W'(1);
          end
          if (!fill) begin
            if (cons_idx == '0) begin
              best     <= logit;
              second   <= MIN_SCORE;
              best_idx <= '0;
            end else if (logit > best) begin
              second   <= best;
              best     <= logit;
              best_idx <= cons_idx;
            end else if (logit > second) begin
              second <= logit;
            end
            cons_idx <= cons_idx + IDX_W'(1);
            if (cons_idx == LAST_IDX) begin
              state <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          class_idx <= best_idx;
          max_score <= best;
          margin    <= diff_c[DATA_W-1:0];
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (start) begin
            done     <= 1'b0;
            up_start <= 1'b1;
            busy     <= 1'b1;
            state    <= S_WAIT_UP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cifar10_argmax_classifier.sv
// Bench for cifar10_argmax_classifier: dense-layer model with async read,
// reference argmax model feeding a scoreboard, monitor checking on done.
module tb_cifar10_argmax_classifier;

  localparam int unsigned N  = 10;
  localparam int unsigned RL = 0;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] score;
    logic [31:0] margin;
  } res_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        up_start;
  logic        up_done;
  logic [3:0]  up_read_addr;
  logic [31:0] up_read_data;
  logic        busy;
  logic        done;
  logic [3:0]  class_idx;
  logic [31:0] max_score;
  logic [31:0] margin;

  logic [31:0] mem [N];
  res_t        sb[$];
  res_t        last_exp;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        done_q = 1'b0;

  cifar10_argmax_classifier #(
    .N_CLASSES(N),
    .READ_LATENCY(RL)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .up_start(up_start),
    .up_done(up_done),
    .up_read_addr(up_read_addr),
    .up_read_data(up_read_data),
    .busy(busy),
    .done(done),
    .class_idx(class_idx),
    .max_score(max_score),
    .margin(margin)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign up_read_data = (up_read_addr < 4'(N)) ? mem[up_read_addr] : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Argmax = first index holding the maximum; runner-up = max over all other entries.
  function automatic res_t ref_model();
    res_t   r;
    int     bi;
    longint sec;
    longint v;
    bi = 0;
    for (int i = 1; i < N; i++)
      if ($signed(mem[i]) > $signed(mem[bi])) bi = i;
    sec = -(longint'(1) <<< 31);
    for (int i = 0; i < N; i++) begin
      if (i != bi) begin
        v = longint'($signed(mem[i]));
        if (v > sec) sec = v;
      end
    end
    r.idx    = 4'(bi);
    r.score  = mem[bi];
    r.margin = 32'(longint'($signed(mem[bi])) - sec);
    return r;
  endfunction

  // Monitor: compare against the scoreboard whenever a result becomes valid.
  always @(negedge clk) begin
    res_t e;
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("class_idx", 32'(class_idx), 32'(e.idx));
        chk("max_score", max_score, e.score);
        chk("margin", margin, e.margin);
        chk("busy_low_at_done", 32'(busy), 32'(0));
        last_exp = e;
      end
    end
    done_q = done;
  end

  task automatic run_case(input int delay, input bit mid_start);
    int t, e, now, hold_bad, ups_bad;
    bit held, fin;
    held = up_done;
    hold_bad = 0;
    ups_bad = 0;
    fin = 1'b0;
    sb.push_back(ref_model());
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = cyc;
    chk("up_start_pulse", 32'(up_start), 32'(1));
    chk("busy_on_start", 32'(busy), 32'(1));
    e = held ? t + 1 : t + delay;
    for (int k = 0; k < 60 && !fin; k++) begin
      @(posedge clk); #1;
      now = cyc;
      if (now == t + 1) chk("up_start_one_cycle", 32'(up_start), 32'(0));
      if (!held && now == e - 1) up_done = 1'b1;
      if (now == e) chk("scan_addr_zero", 32'(up_read_addr), 32'(0));
      if (mid_start && now == e + 3) start = 1'b1;
      if (mid_start && now == e + 4) begin
        start = 1'b0;
        if (up_start) ups_bad++;
      end
      if (done) begin
        fin = 1'b1;
        chk("done_latency", 32'(now - e), 32'(N + RL + 1));
      end else if (class_idx !== last_exp.idx || max_score !== last_exp.score ||
                   margin !== last_exp.margin) begin
        hold_bad++;
      end
    end
    if (!fin) chk("done_timeout", 32'(0), 32'(1));
    chk("results_held", 32'(hold_bad), 32'(0));
    if (mid_start) chk("mid_scan_start_ignored", 32'(ups_bad), 32'(0));
    @(negedge clk);
  endtask

  task automatic run_abort();
    for (int i = 0; i < N; i++) mem[i] = $urandom;
    sb.push_back(ref_model());
    up_done = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    up_done = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("abort_addr_5", 32'(up_read_addr), 32'(5));
    #2;
    resetn = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_addr", 32'(up_read_addr), 32'(0));
    chk("abort_results", {28'(0), class_idx} | max_score | margin, 32'(0));
    sb.delete();
    last_exp = '{4'(0), 32'(0), 32'(0)};
    up_done = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  initial begin
    int nz, ups;
    int basic [N] = '{5, -3, 100, 7, 0, 99, -1000, 2, 3, 4};
    int v;
    last_exp = '{4'(0), 32'(0), 32'(0)};
    resetn = 1'b0;
    start = 1'b0;
    up_done = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 32'(0);

    // reset and idle
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    nz = 0;
    ups = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (up_start) ups++;
      if ({busy, done, up_read_addr, class_idx} != 0 || max_score != 0 || margin != 0) nz++;
    end
    chk("idle_outputs_zero", 32'(nz), 32'(0));
    chk("idle_no_up_start", 32'(ups), 32'(0));

    // basic argmax with an ignored mid-scan start
    for (int i = 0; i < N; i++) mem[i] = 32'(basic[i]);
    run_case(4, 1'b1);
    chk("basic_idx_const", 32'(class_idx), 32'(2));
    chk("basic_margin_const", margin, 32'(1));

    // rerun from DONE with the dense layer's done still high
    mem[9] = 32'(200);
    run_case(0, 1'b0);
    chk("rerun_idx_const", 32'(class_idx), 32'(9));

    // ties and negatives
    up_done = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 32'(-7);
    mem[4] = 32'(-2);
    mem[8] = 32'(-2);
    run_case(3, 1'b0);
    chk("tie_idx_const", 32'(class_idx), 32'(4));
    chk("tie_margin_const", margin, 32'(0));

    // extremes
    up_done = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 32'h8000_0000;
    mem[0] = 32'h7FFF_FFFF;
    run_case(2, 1'b0);
    chk("extreme_margin_const", margin, 32'hFFFF_FFFF);

    // asynchronous reset mid-scan, then a full clean run
    run_abort();
    up_done = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = $urandom;
    run_case(4, 1'b0);

    // randomized runs, half with small values to force ties
    for (int r = 0; r < 8; r++) begin
      up_done = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (r[0]) begin
          v = int'($urandom_range(0, 8)) - 4;
          mem[i] = 32'(v);
        end else begin
          mem[i] = $urandom;
        end
      end
      run_case(int'($urandom_range(2, 6)), r[1]);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cifar10_argmax_classifier.md
# cifar10_argmax_classifier

Final classification stage of the CIFAR-10 CNN pipeline, directly downstream of the 128-to-10 dense output layer. On `start` it launches the dense layer, waits for its `done`, and reads the ten signed 32-bit logits through the dense layer's read port. It computes the winning class index, the winning score and the top-1/top-2 margin, then holds them stable with a sticky `done` for the SoC bus wrapper to read.

## Interface
Parameters:
- `N_CLASSES`, default 10: number of logits scanned, 2..16.
- `READ_LATENCY`, default 0: cycles from `up_read_addr` to valid `up_read_data`. Legal values are 0 (asynchronous BRAM read, as the dense layer provides) or 1 (registered read).

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a classification; sampled only in IDLE and DONE.
- `up_start`  out  1: one-cycle pulse to the dense layer's `start`.
- `up_done`  in  1: dense layer `done`, treated as a level.
- `up_read_addr`  out  4: logit index driven to the dense layer.
- `up_read_data`  in  32: signed logit from the dense layer.
- `busy`  out  1: high from the accepted `start` until `done` rises.
- `done`  out  1: sticky result-valid flag.
- `class_idx`  out  4: argmax index.
- `max_score`  out  32: signed winning logit.
- `margin`  out  32: unsigned value of max_score minus second-best score.

## Operation
- States and transitions:
  - IDLE: on `start`, pulse `up_start` for one cycle, set `busy`, go to WAIT_UP.
  - WAIT_UP: when `up_done` is 1, set idx to 0 and go to SCAN.
  - SCAN: drive `up_read_addr` with idx. Consume one logit per cycle, after the pipeline fill of `READ_LATENCY` cycles.
  - SCAN exit: after logit `N_CLASSES`-1 is consumed, go to FINISH.
  - FINISH: register the results, set `done` to 1 and `busy` to 0, go to DONE.
  - DONE: hold all outputs. On `start`, clear `done`, pulse `up_start`, set `busy`, go to WAIT_UP.
- Scan arithmetic (all compares are signed 32-bit):
  - Logit 0 initialises best to logit 0, second to -2^31 and best index to 0.
  - If logit > best: second takes the old best, best takes the logit, best index takes idx.
  - Else if logit > second: second takes the logit.
  - Ties never replace best, so the lowest index wins a tie. A value equal to best does update second.
- Margin: computed as best minus second in 33 bits, output as the low 32 bits. The result is always in the range 0..2^32-1.
- Outputs `class_idx`, `max_score` and `margin` change only in FINISH. During a rerun they keep the previous result until the new FINISH.
- The dense layer's `done` is sticky. On a second `start` without upstream reset, WAIT_UP exits on the next cycle and the old logits are rescanned. This is the intended behaviour.
- `start` in WAIT_UP, SCAN or FINISH is ignored and not queued.

## Timing
- Reset values: `up_start`, `up_read_addr`, `busy`, `done`, `class_idx`, `max_score` and `margin` are all 0. State is IDLE.
- Reset applied mid-operation clears everything immediately. Any partial scan is discarded.
- `start` sampled high at edge t:
  - `up_start` and `busy` are high after edge t.
  - `up_start` is low after edge t+1.
- `up_done` first seen high at edge e:
  - SCAN starts after e. `up_read_addr` is 0 during cycle e+1.
  - `done` is high after edge e + N_CLASSES + READ_LATENCY + 1. That is e+11 for the defaults.
- With READ_LATENCY=1, the address runs one cycle ahead of the consumed data. `up_read_addr` saturates at `N_CLASSES`-1 during the final drain cycle.
- `done` and `busy` are never high together. `busy` falls on the same edge that `done` rises.

## Test plan
- Reset and idle: hold `resetn`=0 for 3 cycles, then release without `start` -> all outputs remain 0 for 20 cycles and `up_start` never pulses.
- Basic argmax: logits {5,-3,100,7,0,99,-1000,2,3,4}, `up_done` 4 cycles after `up_start` -> `class_idx`=2, `max_score`=100, `margin`=1, and `done` rises exactly 11 cycles after `up_done`.
- Tie and negatives: logits all -7 except index 4 and index 8, both -2 -> `class_idx`=4, `max_score`=-2, `margin`=0.
- Extremes: logit 0 = 32'h7FFFFFFF, logit 1 = 32'h80000000, others 32'h80000000 -> `class_idx`=0, `margin`=32'hFFFFFFFF.
- Rerun and ignored start: pulse `start` during SCAN, then again in DONE with `up_done` held high, and change the logit-9 value to the new maximum -> the mid-scan start has no effect, the rerun yields `class_idx`=9, and the old result is held until the new `done`.
- Asynchronous reset mid-SCAN: assert `resetn`=0 between clock edges at idx 5 -> outputs go to 0 without waiting for a clock edge. A following `start` then produces a correct full result.
